// File: rtl/branch_resolve_if.sv
// Execute-to-writeback bundle for branch_resolve: instruction in, link entry out,
// redirect/exception pulses and performance counters.
interface branch_resolve_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_is_branch;
  logic             in_is_jal;
  logic             in_is_jalr;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_imm;
  logic [XLEN-1:0]  in_rs1;
  logic [4:0]       in_rd;
  logic             cmp_taken;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_rd;
  logic [XLEN-1:0]  out_link;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             misalign_exc;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output in_valid, in_is_branch, in_is_jal, in_is_jalr, in_pc, in_imm, in_rs1, in_rd,
           cmp_taken, pred_taken, pred_target, out_ready,
    input  in_ready, out_valid, out_rd, out_link, redirect_valid, redirect_pc,
           misalign_exc, branch_count, mispredict_count
  );

  modport slave (
    input  in_valid, in_is_branch, in_is_jal, in_is_jalr, in_pc, in_imm, in_rs1, in_rd,
           cmp_taken, pred_taken, pred_target, out_ready,
    output in_ready, out_valid, out_rd, out_link, redirect_valid, redirect_pc,
           misalign_exc, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolve.sv
// Branch/jump resolution: computes the real next PC, redirects on mispredict,
// drops the wrong-path shadow and hands pc+4 link values to writeback.
module branch_resolve #(
  parameter int XLEN          = 32,
  parameter int SHADOW_CYCLES = 2,
  parameter int CNT_W         = 32
) (
  input  logic clk,
  input  logic rst,
  branch_resolve_if.slave bus
);
  localparam int SH_W = $clog2(SHADOW_CYCLES + 1);

  typedef enum logic {RUN, SHADOW} state_t;
  state_t          state_q, state_d;
  logic [SH_W-1:0] sh_q, sh_d;

  logic            is_link, is_ctrl, taken, misalign, mispred, accept, keep;
  logic [XLEN-1:0] seq_pc, br_tgt, jr_sum, target, next_pc;

  always_comb begin
    is_link  = bus.in_is_jal | bus.in_is_jalr;
    is_ctrl  = is_link | bus.in_is_branch;
    taken    = is_link | (bus.in_is_branch & bus.cmp_taken);
    seq_pc   = bus.in_pc + XLEN'(4);
    br_tgt   = bus.in_pc + bus.in_imm;
    jr_sum   = bus.in_rs1 + bus.in_imm;
    target   = bus.in_is_jalr ? {jr_sum[XLEN-1:1], 1'b0} : br_tgt;
    next_pc  = taken ? target : seq_pc;
    misalign = taken & target[1];
    // A misaligned target traps instead of redirecting, so it never opens a shadow.
    mispred  = is_ctrl & ~misalign &
               ((taken != bus.pred_taken) | (taken & (target != bus.pred_target)));
  end

  assign bus.in_ready = (state_q == SHADOW) | ~bus.out_valid | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign keep         = accept & (state_q == RUN);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    case (state_q)
      RUN: begin
        if (keep && mispred) begin
          state_d = SHADOW;
          sh_d    = SH_W'(SHADOW_CYCLES);
        end
      end
      SHADOW: begin
        if (sh_q == SH_W'(1)) begin
          state_d = RUN;
          sh_d    = '0;
        end else begin
          sh_d = sh_q - SH_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        sh_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid        <= 1'b0;
      bus.out_rd           <= '0;
      bus.out_link         <= '0;
      bus.redirect_valid   <= 1'b0;
      bus.redirect_pc      <= '0;
      bus.misalign_exc     <= 1'b0;
      bus.branch_count     <= '0;
      bus.mispredict_count <= '0;
    end else begin
      bus.redirect_valid <= keep & mispred;
      bus.misalign_exc   <= keep & misalign;
      if (keep) begin
        bus.out_valid <= 1'b1;
        bus.out_rd    <= (is_link & ~misalign) ? bus.in_rd : 5'd0;
        bus.out_link  <= seq_pc;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      // redirect_pc also reports the faulting target of a misaligned jump.
      if (keep && (mispred || misalign))
        bus.redirect_pc <= next_pc;
      if (keep && is_ctrl && (bus.branch_count != '1))
        bus.branch_count <= bus.branch_count + CNT_W'(1);
      if (keep && mispred && (bus.mispredict_count != '1))
        bus.mispredict_count <= bus.mispredict_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_branch_resolve;
  localparam int XLEN   = 32;
  localparam int SHADOW = 2;
  localparam int CNT_W  = 2;
  localparam int CMAX   = 3;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  branch_resolve_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_resolve #(.XLEN(XLEN), .SHADOW_CYCLES(SHADOW), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // kind: 0 = non-control, 1 = branch, 2 = jal, 3 = jalr
  task automatic drive(input bit v, input int kind, input logic [31:0] pc, imm, rs1,
                       input logic [4:0] rd, input bit cmp, pt, input logic [31:0] ptgt);
    bus.in_valid     = v;
    bus.in_is_branch = (kind == 1);
    bus.in_is_jal    = (kind == 2);
    bus.in_is_jalr   = (kind == 3);
    bus.in_pc        = pc;
    bus.in_imm       = imm;
    bus.in_rs1       = rs1;
    bus.in_rd        = rd;
    bus.cmp_taken    = cmp;
    bus.pred_taken   = pt;
    bus.pred_target  = ptgt;
  endtask

  task automatic idle();
    drive(1'b0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    idle();
    bus.out_ready = 1'b1;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Architectural outcome of one instruction, straight from the ISA rules.
  function automatic void ref_calc(input int kind, input bit cmp, pt,
                                   input logic [31:0] pc, imm, rs1, ptgt,
                                   output bit ctrl, tk, mis, mp,
                                   output logic [31:0] tgt, npc);
    ctrl = (kind != 0);
    tk   = (kind == 2) || (kind == 3) || (kind == 1 && cmp);
    tgt  = (kind == 3) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    npc  = tk ? tgt : pc + 32'd4;
    mis  = tk && (tgt % 4 != 0);
    mp   = ctrl && !mis && ((tk != pt) || (tk && tgt != ptgt));
  endfunction

  task automatic test_reset();
    drive(1'b1, 1, 32'h100, 32'h20, 32'h0, 5'd3, 1'b1, 1'b0, 32'h0);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    n_vec++;
    if ({bus.out_valid, bus.redirect_valid, bus.misalign_exc, bus.out_rd, bus.out_link,
         bus.redirect_pc, bus.branch_count, bus.mispredict_count} !== '0) begin
      n_err++;
      $display("FAIL reset_state: ov=%0b rv=%0b me=%0b rd=%0d link=%h rpc=%h bc=%0d mc=%0d, required all 0",
               bus.out_valid, bus.redirect_valid, bus.misalign_exc, bus.out_rd, bus.out_link,
               bus.redirect_pc, bus.branch_count, bus.mispredict_count);
    end
    rst = 1'b0;
    idle();
    bus.out_ready = 1'b1;
  endtask

  task automatic test_mispredict_shadow();
    do_reset();
    drive(1'b1, 1, 32'h100, 32'h20, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0);
    cyc();
    n_vec++;
    if ({bus.redirect_valid, bus.redirect_pc, bus.mispredict_count, bus.branch_count,
         bus.out_valid, bus.out_link} !== {1'b1, 32'h120, 2'd1, 2'd1, 1'b1, 32'h104}) begin
      n_err++;
      $display("FAIL beq_redirect: rv=%0b rpc=%h mc=%0d bc=%0d ov=%0b link=%h, required 1 120 1 1 1 104",
               bus.redirect_valid, bus.redirect_pc, bus.mispredict_count, bus.branch_count,
               bus.out_valid, bus.out_link);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 0, 32'h300 + 32'(4 * i), 32'h0, 32'h0, 5'd1, 1'b0, 1'b0, 32'h0);
      cyc();
      n_vec++;
      if (i < 2) begin
        if ({bus.out_valid, bus.redirect_valid} !== 2'b00) begin
          n_err++;
          $display("FAIL shadow_drop%0d: ov=%0b rv=%0b, required 0 0", i, bus.out_valid, bus.redirect_valid);
        end
      end else if ({bus.out_valid, bus.out_link, bus.out_rd} !== {1'b1, 32'h30C, 5'd0}) begin
        n_err++;
        $display("FAIL shadow_exit: ov=%0b link=%h rd=%0d, required 1 30c 0", bus.out_valid, bus.out_link, bus.out_rd);
      end
    end
    idle();
  endtask

  task automatic test_not_taken();
    do_reset();
    drive(1'b1, 1, 32'h200, 32'h40, 32'h0, 5'd7, 1'b0, 1'b0, 32'h0);
    cyc();
    n_vec++;
    if ({bus.redirect_valid, bus.branch_count, bus.mispredict_count, bus.out_valid, bus.out_rd,
         bus.out_link} !== {1'b0, 2'd1, 2'd0, 1'b1, 5'd0, 32'h204}) begin
      n_err++;
      $display("FAIL not_taken: rv=%0b bc=%0d mc=%0d ov=%0b rd=%0d link=%h, required 0 1 0 1 0 204",
               bus.redirect_valid, bus.branch_count, bus.mispredict_count, bus.out_valid,
               bus.out_rd, bus.out_link);
    end
    idle();
  endtask

  task automatic test_jalr();
    do_reset();
    drive(1'b1, 3, 32'h80, 32'h4, 32'h1003, 5'd5, 1'b0, 1'b1, 32'h1000);
    cyc();
    n_vec++;
    if ({bus.misalign_exc, bus.redirect_valid, bus.redirect_pc, bus.mispredict_count,
         bus.branch_count, bus.out_rd} !== {1'b1, 1'b0, 32'h1006, 2'd0, 2'd1, 5'd0}) begin
      n_err++;
      $display("FAIL jalr_misalign: me=%0b rv=%0b rpc=%h mc=%0d bc=%0d rd=%0d, required 1 0 1006 0 1 0",
               bus.misalign_exc, bus.redirect_valid, bus.redirect_pc, bus.mispredict_count,
               bus.branch_count, bus.out_rd);
    end
    drive(1'b1, 3, 32'h40, 32'h3, 32'h1001, 5'd5, 1'b0, 1'b1, 32'h1004);
    cyc();
    n_vec++;
    if ({bus.misalign_exc, bus.redirect_valid, bus.out_valid, bus.out_rd, bus.out_link,
         bus.branch_count} !== {1'b0, 1'b0, 1'b1, 5'd5, 32'h44, 2'd2}) begin
      n_err++;
      $display("FAIL jalr_ok: me=%0b rv=%0b ov=%0b rd=%0d link=%h bc=%0d, required 0 0 1 5 44 2",
               bus.misalign_exc, bus.redirect_valid, bus.out_valid, bus.out_rd, bus.out_link,
               bus.branch_count);
    end
    // No shadow was opened, so the very next instruction must land.
    drive(1'b1, 0, 32'h48, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
    cyc();
    n_vec++;
    if ({bus.out_valid, bus.out_link} !== {1'b1, 32'h4C}) begin
      n_err++;
      $display("FAIL no_shadow: ov=%0b link=%h, required 1 4c", bus.out_valid, bus.out_link);
    end
    idle();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, 0, 32'h500, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
    cyc();
    drive(1'b1, 0, 32'h600, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if ({bus.out_valid, bus.out_link, bus.in_ready} !== {1'b1, 32'h504, 1'b0}) begin
        n_err++;
        $display("FAIL stall%0d: ov=%0b link=%h in_ready=%0b, required 1 504 0",
                 i, bus.out_valid, bus.out_link, bus.in_ready);
      end
      cyc();
    end
    bus.out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 0, 32'h600 + 32'(4 * j), 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
      cyc();
      n_vec++;
      if ({bus.out_valid, bus.out_link} !== {1'b1, 32'h604 + 32'(4 * j)}) begin
        n_err++;
        $display("FAIL b2b%0d: ov=%0b link=%h, required 1 %h", j, bus.out_valid, bus.out_link,
                 32'h604 + 32'(4 * j));
      end
    end
    idle();
  endtask

  task automatic test_wrap_saturation();
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1, 32'hFFFF_FFFC, 32'h10, 32'h0, 5'd0, 1'b0, 1'b1, 32'h0000_000C);
      cyc();
      n_vec++;
      if ({bus.redirect_valid, bus.redirect_pc, bus.out_link, bus.mispredict_count} !==
          {1'b1, 32'h0, 32'h0, 2'((k > CMAX) ? CMAX : k)}) begin
        n_err++;
        $display("FAIL wrap_sat%0d: rv=%0b rpc=%h link=%h mc=%0d, required 1 0 0 %0d",
                 k, bus.redirect_valid, bus.redirect_pc, bus.out_link, bus.mispredict_count,
                 (k > CMAX) ? CMAX : k);
      end
      idle();
      cyc();
      cyc();
    end
  endtask

  task automatic test_reset_mid_shadow();
    do_reset();
    drive(1'b1, 2, 32'h100, 32'h80, 32'h0, 5'd1, 1'b0, 1'b0, 32'h0);
    cyc();
    drive(1'b1, 0, 32'h900, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_vec++;
    if ({bus.out_valid, bus.redirect_valid, bus.branch_count, bus.mispredict_count} !== '0) begin
      n_err++;
      $display("FAIL mid_shadow_rst: ov=%0b rv=%0b bc=%0d mc=%0d, required 0 0 0 0",
               bus.out_valid, bus.redirect_valid, bus.branch_count, bus.mispredict_count);
    end
    bus.out_ready = 1'b0;
    drive(1'b1, 0, 32'h700, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
    cyc();
    #1;
    n_vec++;
    if ({bus.out_valid, bus.out_link, bus.in_ready} !== {1'b1, 32'h704, 1'b0}) begin
      n_err++;
      $display("FAIL post_rst_run: ov=%0b link=%h in_ready=%0b, required 1 704 0",
               bus.out_valid, bus.out_link, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    idle();
  endtask

  task automatic test_random();
    int          m_drop, m_bc, m_mc;
    bit          m_ov, m_rv, m_mis, exp_ready, v, cmp, pt, rst_c, ctrl, tk, mis, mp;
    logic [4:0]  m_rd, rd;
    logic [31:0] m_link, m_rpc, pc, imm, rs1, ptgt, tgt, npc;
    int          kind;
    do_reset();
    m_drop = 0; m_bc = 0; m_mc = 0; m_ov = 0; m_rv = 0; m_mis = 0;
    m_rd = 0; m_link = 0; m_rpc = 0;
    for (int c = 0; c < 600; c++) begin
      kind = $urandom_range(0, 3);
      v    = ($urandom_range(0, 3) != 0);
      cmp  = $urandom_range(0, 1);
      pc   = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) pc = 32'hFFFF_FFF8 | (pc & 32'h4);
      imm  = 32'($urandom_range(0, 63) * 4) - 32'd128;
      if ($urandom_range(0, 3) == 0) imm = imm + 32'd2;
      rs1  = $urandom;
      rd   = 5'($urandom_range(0, 31));
      ref_calc(kind, cmp, 1'b0, pc, imm, rs1, 32'h0, ctrl, tk, mis, mp, tgt, npc);
      if ($urandom_range(0, 1) == 1) begin
        pt = tk; ptgt = tgt;
      end else begin
        pt = $urandom_range(0, 1); ptgt = $urandom & 32'hFFFF_FFFC;
      end
      ref_calc(kind, cmp, pt, pc, imm, rs1, ptgt, ctrl, tk, mis, mp, tgt, npc);
      drive(v, kind, pc, imm, rs1, rd, cmp, pt, ptgt);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst_c = (c % 97 == 96);
      rst = rst_c;
      exp_ready = (m_drop > 0) || !m_ov || bus.out_ready;
      #1;
      n_vec++;
      if (bus.in_ready !== exp_ready) begin
        n_err++;
        $display("FAIL rnd_in_ready c=%0d: got %0b, required %0b", c, bus.in_ready, exp_ready);
      end
      cyc();
      if (rst_c) begin
        m_drop = 0; m_bc = 0; m_mc = 0; m_ov = 0; m_rv = 0; m_mis = 0;
        m_rd = 0; m_link = 0; m_rpc = 0;
      end else begin
        bit keep;
        keep  = v && exp_ready && (m_drop == 0);
        if (m_drop > 0) m_drop--;
        m_rv  = 0;
        m_mis = 0;
        if (keep) begin
          m_ov   = 1;
          m_link = pc + 32'd4;
          m_rd   = ((kind == 2 || kind == 3) && !mis) ? rd : 5'd0;
          if (ctrl && m_bc < CMAX) m_bc++;
          if (mis) begin
            m_mis = 1; m_rpc = tgt;
          end else if (mp) begin
            m_rv = 1; m_rpc = npc; m_drop = SHADOW;
            if (m_mc < CMAX) m_mc++;
          end
        end else if (bus.out_ready) begin
          m_ov = 0;
        end
      end
      rst = 1'b0;
      n_vec++;
      if ({bus.out_valid, bus.redirect_valid, bus.misalign_exc, bus.redirect_pc,
           bus.branch_count, bus.mispredict_count} !==
          {m_ov, m_rv, m_mis, m_rpc, 2'(m_bc), 2'(m_mc)} ||
          (m_ov && {bus.out_rd, bus.out_link} !== {m_rd, m_link})) begin
        n_err++;
        $display("FAIL rnd_out c=%0d: ov=%0b rv=%0b me=%0b rpc=%h bc=%0d mc=%0d rd=%0d link=%h, required %0b %0b %0b %h %0d %0d %0d %h",
                 c, bus.out_valid, bus.redirect_valid, bus.misalign_exc, bus.redirect_pc,
                 bus.branch_count, bus.mispredict_count, bus.out_rd, bus.out_link,
                 m_ov, m_rv, m_mis, m_rpc, m_bc, m_mc, m_rd, m_link);
      end
    end
    idle();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_mispredict_shadow();
    test_not_taken();
    test_jalr();
    test_backpressure();
    test_wrap_saturation();
    test_reset_mid_shadow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Execute-stage block directly downstream of the `compare` unit.
- Consumes the compare `result` (`cmp_taken`) with the decoded branch/jump fields. Computes the actual next PC and checks it against the fetch prediction.
- On a mismatch it issues a one-cycle redirect/flush, then drops wrong-path instructions for a fixed shadow window.
- Passes the link value (pc+4) to writeback through a registered valid/ready stage and keeps saturating performance counters.

Parameters:
XLEN, 32, datapath/address width
SHADOW_CYCLES, 2, cycles after a redirect during which accepted inputs are discarded (>=1)
CNT_W, 32, width of performance counters

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  execute-stage instruction valid
in_ready  output  1  block can accept input this cycle
in_is_branch  input  1  conditional branch (uses cmp_taken)
in_is_jal  input  1  JAL
in_is_jalr  input  1  JALR
in_pc  input  XLEN  instruction PC
in_imm  input  XLEN  sign-extended immediate
in_rs1  input  XLEN  rs1 value (JALR base)
in_rd  input  5  destination register
cmp_taken  input  1  compare unit result for this instruction
pred_taken  input  1  fetch predicted taken
pred_target  input  XLEN  fetch predicted target
out_valid  output  1  writeback entry valid
out_ready  input  1  writeback accepts entry
out_rd  output  5  link destination (0 when no write)
out_link  output  XLEN  pc+4
redirect_valid  output  1  one-cycle redirect/flush pulse
redirect_pc  output  XLEN  correct next PC
misalign_exc  output  1  one-cycle pulse: taken target not 4-byte aligned
branch_count  output  CNT_W  resolved branches/jumps
mispredict_count  output  CNT_W  redirects issued

Behaviour:
- Accept: in_valid && in_ready at a clk edge.
- In RUN, in_ready = !out_valid || out_ready. In SHADOW, in_ready = 1.
- Reset (rst high at a clk edge): state=RUN, shadow counter=0. out_valid, redirect_valid and misalign_exc all 0. out_rd, out_link, redirect_pc, branch_count and mispredict_count all 0. rst has priority over all other inputs and aborts any shadow window or held output.
- Actual outcome:
  - taken = is_jal | is_jalr | (is_branch & cmp_taken).
  - Target for branch/JAL = in_pc + in_imm, mod 2^XLEN (wraps).
  - Target for JALR = (in_rs1 + in_imm) & ~1.
  - next_pc = taken ? target : in_pc + 4 (wraps).
- Mispredict (control-flow instructions only) when taken != pred_taken, or when taken && target != pred_target.
- Non-control instructions (all three flags 0):
  - Pass through as out_rd = 0 entries.
  - No redirect; no counter change.
- Misalign: if taken && target[1] = 1:
  - misalign_exc pulses 1 the cycle after accept.
  - No redirect pulse, no SHADOW entry, mispredict_count unchanged.
  - out_rd forced 0; branch_count still increments.
- Latency: all outputs are registered, one cycle after accept.
  - redirect_valid/redirect_pc assert for exactly one cycle, independent of out_ready.
  - redirect_pc holds its value until the next redirect.
- Writeback stage:
  - Every accepted instruction loads out_valid=1.
  - out_rd = (jal|jalr) ? in_rd : 0; out_link = in_pc + 4.
  - Data holds stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new accept occurs in the same cycle (back-to-back throughput of 1/cycle).
- State machine:
  - RUN -> SHADOW on accepting a mispredicted instruction (non-misaligned). The shadow counter loads SHADOW_CYCLES.
  - SHADOW: inputs are accepted and silently dropped (no output entry, no counters, no redirect). The counter decrements each cycle. At 1 it returns to RUN, so the window is exactly SHADOW_CYCLES cycles starting the cycle after the redirect accept.
  - The out stage continues draining during SHADOW.
- Counters:
  - branch_count += 1 per accepted (non-dropped) control instruction.
  - mispredict_count += 1 per redirect.
  - Both saturate at 2^CNT_W-1 (no wrap).

Test Plan:
- Reset mid-SHADOW: mispredict accepted, then rst asserted 1 cycle later -> next cycle state RUN, in_ready follows out stage, counters 0, no further drops.
- BEQ-type, pc=0x100, imm=0x20, cmp_taken=1, pred_taken=0 -> next cycle redirect_valid=1, redirect_pc=0x120, mispredict_count=1. The next 2 inputs are dropped (no out_valid for them); the 3rd input appears on out.
- Branch pc=0x200, cmp_taken=0, pred_taken=0 -> no redirect, branch_count=1, out_valid=1, out_rd=0, out_link=0x204.
- JALR rs1=0x1003, imm=0x4, rd=5, pred_target=0x1000 -> redirect_pc=0x1006 with misalign_exc=1 and no redirect/shadow. With rs1=0x1001, imm=0x3 -> target 0x1004; pred_target 0x1004 -> no redirect, out_rd=5, out_link=pc+4.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, out data stable for 5 cycles; releasing out_ready with in_valid=1 gives one transfer per cycle thereafter.
- Wrap/saturation: pc=0xFFFFFFFC non-taken -> out_link=0x00000000, redirect_pc (if mispredicted) 0x00000000. With CNT_W=2, 5 mispredicts -> mispredict_count stays at 3.
